// File: rtl/adc_pkg.sv
// adc_pkg: shared constants and helpers for the XADC moving-average filter.
//   - XADC result slice (do_out is left-justified, result in [15:4])
//   - aux channel DRP addresses
//   - clog2 / channel-tag width helpers
package adc_pkg;

  localparam int XADC_MSB = 15;
  localparam int XADC_LSB = 4;
  localparam int XADC_W   = 12;

  localparam logic [6:0] DRP_ADDR_VAUX6  = 7'h16;
  localparam logic [6:0] DRP_ADDR_VAUX7  = 7'h17;
  localparam logic [6:0] DRP_ADDR_VAUX14 = 7'h1E;
  localparam logic [6:0] DRP_ADDR_VAUX15 = 7'h1F;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  // Channel tag width, never narrower than one bit.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/adc_moving_avg_if.sv
// adc_moving_avg_if: sample stream into the filter and averaged stream out.
//   s_valid/s_ch/s_data : tagged raw XADC words (no backpressure)
//   m_valid/m_ch/m_data : tagged averages, one per accepted sample
//   m_primed            : per-channel "window full" flags
//   master modport = producer/consumer side, slave modport = filter side.
interface adc_moving_avg_if #(
  parameter int NUM_CH = 4
);
  import adc_pkg::*;

  localparam int CH_W = ch_width(NUM_CH);

  logic              s_valid;
  logic [CH_W-1:0]   s_ch;
  logic [15:0]       s_data;
  logic              m_valid;
  logic [CH_W-1:0]   m_ch;
  logic [XADC_W-1:0] m_data;
  logic [NUM_CH-1:0] m_primed;

  modport master (
    output s_valid, s_ch, s_data,
    input  m_valid, m_ch, m_data, m_primed
  );

  modport slave (
    input  s_valid, s_ch, s_data,
    output m_valid, m_ch, m_data, m_primed
  );

endinterface

// File: rtl/adc_avg_lane.sv
// adc_avg_lane: one channel's boxcar state (history, write pointer,
// running sum, fill count).
//   clk, rst     : clock, async active-high reset
//   i_flush      : synchronous clear of all lane state
//   i_en         : accept i_x this cycle
//   i_x          : 12-bit sample
//   o_acc_next   : running sum including i_x (valid whenever i_en is high)
//   o_primed     : window has been filled since the last clear
module adc_avg_lane
  import adc_pkg::*;
#(
  parameter int LOG2_LEN = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_en,
  input  logic [XADC_W-1:0]          i_x,
  output logic [XADC_W+LOG2_LEN-1:0] o_acc_next,
  output logic                       o_primed
);

  localparam int LEN    = 1 << LOG2_LEN;
  localparam int ACC_W  = XADC_W + LOG2_LEN;
  localparam int FILL_W = LOG2_LEN + 1;

  logic [XADC_W-1:0]   r_hist [LEN];
  logic [LOG2_LEN-1:0] r_ptr;
  logic [ACC_W-1:0]    r_acc;
  logic [FILL_W-1:0]   r_fill;
  logic                r_primed;

  logic [ACC_W-1:0]    w_acc_next;
  logic [FILL_W-1:0]   w_fill_next;

  // Running-sum update and saturating fill count. The sum of the other
  // window entries plus x always fits ACC_W, so modular arithmetic is exact.
  always_comb begin
    w_acc_next = r_acc + ACC_W'(i_x) - ACC_W'(r_hist[r_ptr]);
    if (r_fill == FILL_W'(LEN)) begin
      w_fill_next = r_fill;
    end else begin
      w_fill_next = r_fill + FILL_W'(1'b1);
    end
  end

  // Lane state: cleared by reset or flush, advanced on each accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LEN; i++) begin
        r_hist[i] <= {XADC_W{1'b0}};
      end
      r_ptr    <= {LOG2_LEN{1'b0}};
      r_acc    <= {ACC_W{1'b0}};
      r_fill   <= {FILL_W{1'b0}};
      r_primed <= 1'b0;
    end else if (i_flush) begin
      for (int i = 0; i < LEN; i++) begin
        r_hist[i] <= {XADC_W{1'b0}};
      end
      r_ptr    <= {LOG2_LEN{1'b0}};
      r_acc    <= {ACC_W{1'b0}};
      r_fill   <= {FILL_W{1'b0}};
      r_primed <= 1'b0;
    end else if (i_en) begin
      r_hist[r_ptr] <= i_x;
      r_ptr         <= r_ptr + LOG2_LEN'(1'b1);
      r_acc         <= w_acc_next;
      r_fill        <= w_fill_next;
      // Registered alongside the output strobe so it rises with m_valid.
      r_primed      <= (w_fill_next == FILL_W'(LEN));
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign o_acc_next = w_acc_next;
  assign o_primed   = r_primed;

endmodule

// File: rtl/adc_moving_avg.sv
// adc_moving_avg: per-channel 2^LOG2_LEN-tap moving average of XADC words.
//   clk, rst : clock, async active-high reset
//   flush    : synchronous clear of all filter state
//   bus      : slave side of adc_moving_avg_if (s_* in, m_* out)
// One lane per channel; the selected lane's new sum is shifted down and
// registered as the channel-tagged average one cycle after the sample.
module adc_moving_avg
  import adc_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int LOG2_LEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  adc_moving_avg_if.slave   bus
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int ACC_W = XADC_W + LOG2_LEN;

  logic [XADC_W-1:0] w_x;
  logic              w_accept;
  logic [NUM_CH-1:0] w_en;
  logic [NUM_CH-1:0] w_primed;
  logic [ACC_W-1:0]  w_acc_next [NUM_CH];
  logic [ACC_W-1:0]  w_acc_sel;

  logic              r_m_valid;
  logic [CH_W-1:0]   r_m_ch;
  logic [XADC_W-1:0] r_m_data;

  assign w_x = XADC_W'(bus.s_data >> XADC_LSB);

  // Out-of-range channel tags and samples coinciding with flush are dropped.
  assign w_accept = bus.s_valid & ~flush & (32'(bus.s_ch) < 32'(NUM_CH));

  // Channel decode into lane enables and mux of the selected lane's sum.
  always_comb begin
    w_en      = {NUM_CH{1'b0}};
    w_acc_sel = {ACC_W{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_accept && (bus.s_ch == CH_W'(c))) begin
        w_en[c]   = 1'b1;
        w_acc_sel = w_acc_next[c];
      end else begin
        w_en[c]   = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    adc_avg_lane #(
      .LOG2_LEN (LOG2_LEN)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (flush),
      .i_en       (w_en[g]),
      .i_x        (w_x),
      .o_acc_next (w_acc_next[g]),
      .o_primed   (w_primed[g])
    );
  end

  // Output register: strobe every cycle, tag/data only on accepted samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_ch    <= {CH_W{1'b0}};
      r_m_data  <= {XADC_W{1'b0}};
    end else begin
      r_m_valid <= w_accept;
      if (w_accept) begin
        r_m_ch   <= bus.s_ch;
        r_m_data <= XADC_W'(w_acc_sel >> LOG2_LEN);
      end else begin
        r_m_data <= r_m_data;
      end
    end
  end

  assign bus.m_valid  = r_m_valid;
  assign bus.m_ch     = r_m_ch;
  assign bus.m_data   = r_m_data;
  assign bus.m_primed = w_primed;

endmodule

// File: doc/adc_moving_avg.md
# adc_moving_avg

Per-channel moving-average filter sitting directly downstream of the XADC DRP reader. Accepts tagged 16-bit conversion words (XADC `do_out` format, result left-justified in bits [15:4]) and keeps an independent 2^LOG2_LEN-tap boxcar history and running sum for each auxiliary channel. It emits one registered, channel-tagged average per accepted sample. Consumers are the LED PWM duty registers and later filter stages.

## Interface
- `NUM_CH`, default 4: number of channels; channel tag width CH_W = clog2(NUM_CH), minimum 1.
- `LOG2_LEN`, default 3: log2 of window length (8 taps); legal range 1..6.
- `clk` in 1: sole clock; all state is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of all filter state.
- `s_valid` in 1: input sample strobe, one-cycle qualifier, no backpressure.
- `s_ch` in CH_W: channel index of the sample.
- `s_data` in 16: raw XADC word; only [15:4] is used.
- `m_valid` out 1: output strobe, one cycle.
- `m_ch` out CH_W: channel of the output.
- `m_data` out 12: filtered average.
- `m_primed` out NUM_CH: bit c is set once channel c's window is full.

## Operation
- Sample x = s_data[15:4], unsigned 12 bits.
- Per-channel state:
  - history array hist[c][0..2^LOG2_LEN-1], 12 bits each;
  - write pointer ptr[c], LOG2_LEN bits;
  - accumulator acc[c], 12+LOG2_LEN bits;
  - fill counter fill[c], saturating at 2^LOG2_LEN.
- Accepted sample (s_valid=1, s_ch<NUM_CH, flush=0), all updates in that same cycle:
  - acc_next = acc[c] + x - hist[c][ptr[c]]
  - acc[c] <= acc_next
  - hist[c][ptr[c]] <= x
  - ptr[c] <= ptr[c]+1 (wraps modulo 2^LOG2_LEN)
  - fill[c] increments, saturating at 2^LOG2_LEN
  - m_data <= acc_next >> LOG2_LEN (truncating); m_ch <= c; m_valid <= 1
- Accumulator width is exact; overflow and underflow are impossible and no saturation logic is needed.
- Fill behaviour: history starts at zero, so outputs ramp during fill. m_primed[c] is 1 exactly when fill[c] == 2^LOG2_LEN.
- s_ch >= NUM_CH: sample is dropped with no state change and no output. Unreachable when NUM_CH is a power of two.
- flush=1: clears all hist, acc, ptr, fill and m_primed to 0 and forces m_valid <= 0. A sample presented in the same cycle is discarded.
- rst: same clearing as flush, applied asynchronously. Also clears m_data and m_ch.

## Timing
- Latency is 1 cycle: a sample accepted at edge N produces m_valid high for the cycle after edge N.
- Throughput is one sample per cycle, any channel order, including back-to-back samples on the same channel. Same-cycle read-modify-write is used, so no hazard or forwarding is needed.
- m_valid is high for one cycle per accepted sample. m_data and m_ch hold their last values while m_valid=0.
- Reset values: m_valid=0, m_ch=0, m_data=0, m_primed=0.
- m_primed[c] rises in the same cycle that m_valid rises for the 2^LOG2_LEN-th sample of channel c.
- Reset asserted mid-stream: all outputs go to zero immediately, without waiting for a clock edge. The first sample after release behaves as a fresh fill.

## Structure
- Shared package `adc_pkg`:
  - XADC sample slice constants (MSB 15, LSB 4, width 12);
  - aux channel DRP address constants (0x16, 0x17, 0x1E, 0x1F);
  - a clog2 helper.
- One sub-module, `adc_avg_lane`, per channel, holding that channel's hist, ptr, acc and fill. Each lane exposes an enable, x, acc_next and primed.
- The top level instantiates NUM_CH lanes via generate, decodes s_ch into lane enables, and muxes the selected acc_next into the output register.

## Test plan
- Reset, then 8 samples on ch0 with s_data=0x8000 (x=0x800): m_data = 0x100, 0x200, …, 0x800, each 1 cycle after its input. m_primed = 4'b0001 with the 8th output.
- Window step: ch0 primed at 0x800, then 8 samples with x=0xFFF. Outputs are 0x8FF first, rising each sample, last 0xFFF. m_primed[0] stays 1.
- Interleaved, every cycle: ch0..ch3 round-robin with x = 0x100, 0x200, 0x300, 0x400 for 8 rounds. In the final round m_data equals each channel's constant, m_ch is correct, and there is no cross-talk between channels.
- Same channel every cycle: 16 samples of x=0xFFF on ch2. Outputs are 0x1FF, 0x3FF, 0x5FF, …, 0xFFF, then hold at 0xFFF. No overflow; internal acc is 0x7FF8.
- flush asserted together with s_valid on primed ch1: no m_valid the next cycle, m_primed=0. The next sample x=0x800 on ch1 gives 0x100.
- Async rst pulse between clock edges while streaming: m_valid, m_data and m_primed go to 0 before the next edge. The first post-reset sample x=0x400 yields 0x080.
